// File: rtl/barrel_shifter_pkg.sv
// Shared definitions for the pipelined barrel shifter.
//   mode_t   : 2-bit shift/rotate mode selector
//   MODE_*   : encodings for ROR, ROL, SRL and SRA
package barrel_shifter_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_ROR = 2'b00;
  localparam mode_t MODE_ROL = 2'b01;
  localparam mode_t MODE_SRL = 2'b10;
  localparam mode_t MODE_SRA = 2'b11;

endpackage

// File: rtl/bshift_stage.sv
// One log stage of the pipelined barrel shifter.
// Applies a constant move of DIST bit positions when the matching shamt bit
// is set, then registers the result together with the word's valid bit,
// mode, shift amount and original sign bit.
//
// Optional: BARREL_SHIFTER_PIPE_FLAG_EN adds o_zero, a registered
// "result is zero" flag that travels alongside o_data.
//
// Ports:
//   i_clk, i_rstn        clock, asynchronous active-low reset
//   i_en                 pipeline advance; all registers hold when low
//   i_valid/o_valid      slot valid in / out
//   i_data/o_data        data word in / moved word out
//   i_mode/o_mode        shift mode, passed along
//   i_shamt/o_shamt      full shift amount, passed along
//   i_sign/o_sign        original operand MSB, SRA fill value
//   o_zero               (flag build only) registered o_data == 0
module bshift_stage
  import barrel_shifter_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DIST   = 1
) (
  input  logic                       i_clk,
  input  logic                       i_rstn,
  input  logic                       i_en,
  input  logic                       i_valid,
  input  logic [DATA_W-1:0]          i_data,
  input  mode_t                      i_mode,
  input  logic [$clog2(DATA_W)-1:0]  i_shamt,
  input  logic                       i_sign,
  output logic                       o_valid,
  output logic [DATA_W-1:0]          o_data,
  output mode_t                      o_mode,
  output logic [$clog2(DATA_W)-1:0]  o_shamt,
`ifdef BARREL_SHIFTER_PIPE_FLAG_EN
  output logic                       o_zero,
`endif
  output logic                       o_sign
);

  localparam int SHAMT_W = $clog2(DATA_W);
  localparam int SEL_BIT = $clog2(DIST);
  // Top DIST bits set: the positions vacated by a right shift.
  localparam logic [DATA_W-1:0] FILL_MASK = ~({DATA_W{1'b1}} >> DIST);

  logic [DATA_W-1:0]  data_d;
  logic               valid_q;
  logic [DATA_W-1:0]  data_q;
  mode_t              mode_q;
  logic [SHAMT_W-1:0] shamt_q;
  logic               sign_q;

  // NOTE: default assignment first so every path drives data_d; otherwise
  // a latch is inferred when the shamt bit is clear.
  always_comb begin
    data_d = i_data;
    if (i_shamt[SEL_BIT]) begin
      case (i_mode)
        MODE_ROR: data_d = (i_data >> DIST) | (i_data << (DATA_W - DIST));
        MODE_ROL: data_d = (i_data << DIST) | (i_data >> (DATA_W - DIST));
        MODE_SRL: data_d = i_data >> DIST;
        MODE_SRA: data_d = (i_data >> DIST) | (i_sign ? FILL_MASK : '0);
        default:  data_d = i_data;
      endcase
    end
  end

  // NOTE: non-blocking assignments so every stage samples its predecessor's
  // pre-edge value. Payload registers are reset too, because o_data must read
  // 0 after reset, and they load only for valid slots so bubbles never
  // disturb the last delivered result.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      mode_q  <= MODE_ROR;
      shamt_q <= '0;
      sign_q  <= 1'b0;
    end else if (i_en) begin
      valid_q <= i_valid;
      if (i_valid) begin
        data_q  <= data_d;
        mode_q  <= i_mode;
        shamt_q <= i_shamt;
        sign_q  <= i_sign;
      end
    end
  end

`ifdef BARREL_SHIFTER_PIPE_FLAG_EN
  logic zero_q;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      zero_q <= 1'b0;
    end else if (i_en && i_valid) begin
      zero_q <= (data_d == '0);
    end
  end

  assign o_zero = zero_q;
`endif

  assign o_valid = valid_q;
  assign o_data  = data_q;
  assign o_mode  = mode_q;
  assign o_shamt = shamt_q;
  assign o_sign  = sign_q;

endmodule

// File: rtl/barrel_shifter_pipe.sv
// Pipelined DATA_W-bit barrel shifter/rotator with valid/ready handshake.
// One registered stage per shamt bit, largest move first; latency SHAMT_W
// cycles, one word per cycle. The whole pipeline stalls when the output is
// held (o_valid & !i_ready); bubbles are not collapsed.
//
// Optional: define BARREL_SHIFTER_PIPE_FLAG_EN to add o_zero, a registered
// flag that is 1 when the delivered result is zero.
//
// Ports:
//   i_clk, i_rstn   clock, asynchronous active-low reset
//   i_valid/o_ready input handshake (o_ready is combinational)
//   i_data          operand
//   i_shamt         shift/rotate amount 0..DATA_W-1
//   i_mode          00 ROR, 01 ROL, 10 SRL, 11 SRA
//   o_valid/i_ready output handshake
//   o_data          result, held while stalled
//   o_zero          (flag build only) result == 0
module barrel_shifter_pipe
  import barrel_shifter_pkg::*;
#(
  parameter  int DATA_W  = 32,
  localparam int SHAMT_W = $clog2(DATA_W)
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [DATA_W-1:0]  i_data,
  input  logic [SHAMT_W-1:0] i_shamt,
  input  logic [1:0]         i_mode,
  output logic               o_valid,
  input  logic               i_ready,
`ifdef BARREL_SHIFTER_PIPE_FLAG_EN
  output logic               o_zero,
`endif
  output logic [DATA_W-1:0]  o_data
);

  logic advance;

  // Index 0 is the input port, index s+1 is the output of stage s.
  logic               valid_s [SHAMT_W+1];
  logic [DATA_W-1:0]  data_s  [SHAMT_W+1];
  mode_t              mode_s  [SHAMT_W+1];
  logic [SHAMT_W-1:0] shamt_s [SHAMT_W+1];
  logic               sign_s  [SHAMT_W+1];
`ifdef BARREL_SHIFTER_PIPE_FLAG_EN
  logic               zero_s  [SHAMT_W];
`endif

  // Room exists whenever the output slot is empty or being drained.
  assign advance = !o_valid || i_ready;
  assign o_ready = advance;

  assign valid_s[0] = i_valid;
  assign data_s[0]  = i_data;
  assign mode_s[0]  = mode_t'(i_mode);
  assign shamt_s[0] = i_shamt;
  assign sign_s[0]  = i_data[DATA_W-1];

  for (genvar s = 0; s < SHAMT_W; s++) begin : g_stage
    bshift_stage #(
      .DATA_W (DATA_W),
      .DIST   (1 << (SHAMT_W - 1 - s))
    ) u_stage (
      .i_clk   (i_clk),
      .i_rstn  (i_rstn),
      .i_en    (advance),
      .i_valid (valid_s[s]),
      .i_data  (data_s[s]),
      .i_mode  (mode_s[s]),
      .i_shamt (shamt_s[s]),
      .i_sign  (sign_s[s]),
      .o_valid (valid_s[s+1]),
      .o_data  (data_s[s+1]),
      .o_mode  (mode_s[s+1]),
      .o_shamt (shamt_s[s+1]),
`ifdef BARREL_SHIFTER_PIPE_FLAG_EN
      .o_zero  (zero_s[s]),
`endif
      .o_sign  (sign_s[s+1])
    );
  end

  assign o_valid = valid_s[SHAMT_W];
  assign o_data  = data_s[SHAMT_W];
`ifdef BARREL_SHIFTER_PIPE_FLAG_EN
  assign o_zero  = zero_s[SHAMT_W-1];
`endif

endmodule

// File: doc/barrel_shifter_pipe.md
Name: barrel_shifter_pipe

Overview:
- Parametrised, pipelined successor to the 8-bit combinational rotator.
- Shifts or rotates a DATA_W-bit word by 0..DATA_W-1 in one of four modes.
- Uses one registered mux stage per shift-amount bit, ordered MSB stage first.
- Carries a valid/ready handshake on input and output, with full-pipeline stall under backpressure; sits between datapath producer/consumer blocks at one sample per cycle.

Parameters:
- DATA_W, 32, data width; power of two, at least 4.
- SHAMT_W, $clog2(DATA_W), shift-amount width and pipeline depth; derived, never overridden.

Ports:
- i_clk  input  1  sole clock, rising edge.
- i_rstn  input  1  reset; asynchronous, active-low.
- i_valid  input  1  input word valid.
- o_ready  output  1  block can accept an input this cycle.
- i_data  input  DATA_W  operand.
- i_shamt  input  SHAMT_W  shift/rotate amount.
- i_mode  input  2  00 ROR, 01 ROL, 10 SRL, 11 SRA.
- o_valid  output  1  result valid.
- i_ready  input  1  downstream accepts the result.
- o_data  output  DATA_W  result.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (i_clk, i_rstn).
- Reset values: all stage valid bits 0, o_valid=0, o_data=0. o_ready=1 out of reset, because it is combinational: o_ready = advance.
- advance = !o_valid | i_ready. When advance=1, every stage register loads from its predecessor; when advance=0, every stage holds.
- Input handshake: a word is accepted when i_valid & o_ready. If o_ready=0, the input is ignored and upstream must hold it stable.
- Output handshake: a word is consumed when o_valid & i_ready. While o_valid & !i_ready, o_data is held stable.
- Latency: exactly SHAMT_W cycles from accept to o_valid when there is no stall. Throughput is 1 word/cycle. Bubbles are not collapsed.
- Stage s (s=0..SHAMT_W-1) applies a move of 2^(SHAMT_W-1-s) if shamt bit (SHAMT_W-1-s) is set. Mode and the remaining shamt bits travel with the data.
- ROR: out[i] = in[(i+k) mod DATA_W].
- ROL: out[i] = in[(i-k) mod DATA_W].
- SRL: right shift, fill with 0.
- SRA: right shift, fill with in[DATA_W-1] of the original operand (sign bit is carried per stage).
- k=0: result equals operand in all modes.
- Invalid slots: payload contents are don't-care. o_data is don't-care while o_valid=0, except that it is 0 after reset until the first valid result.
- Reset mid-operation: all in-flight words are discarded, with no partial output; the first accept after release produces a result SHAMT_W cycles later.
- Simultaneous accept and consume in the same cycle (full pipeline with i_ready=1): both occur, and no word is lost or duplicated.

Optional Feature:
- Macro: BARREL_SHIFTER_PIPE_FLAG_EN.
- Defined: adds output port o_zero (1 bit), registered alongside o_data, =1 when result == 0; reset 0; held during stall.
- Undefined: port absent, no extra logic.

Decomposition:
- Shared package barrel_shifter_pkg holds:
  - mode localparams MODE_ROR=2'b00, MODE_ROL=2'b01, MODE_SRL=2'b10, MODE_SRA=2'b11;
  - the 2-bit mode typedef.
- Sub-module bshift_stage (parameters DATA_W, DIST) covers one log stage: direction/fill mux plus the valid/data/mode/shamt/sign register with enable. It is instantiated SHAMT_W times via generate.
- The top level contains only the handshake and generate loop.

Test Plan:
- DATA_W=8, ROR 0x96 k=3 -> 0xD2; ROL 0x96 k=3 -> 0xB4; SRL 0x96 k=3 -> 0x12; SRA 0x96 k=3 -> 0xF2. Each with o_valid exactly 3 cycles after accept.
- Back-to-back stream of 16 random words with i_ready=1 -> 16 results in order, one per cycle; matches reference model for all modes and k=0..7.
- Hold i_ready=0 for 5 cycles with the pipeline full -> o_ready=0, o_data/o_valid stable. Release -> no loss or duplication; order preserved.
- Assert i_rstn=0 with 3 words in flight -> o_valid=0 and o_data=0 immediately (async). After release, no stale result appears.
- k=0 in each mode with 0xA5 -> 0xA5. SRA 0x80 k=7 -> 0xFF; SRL 0x80 k=7 -> 0x01.
- FLAG_EN defined: SRL 0x01 k=1 -> o_data=0x00, o_zero=1. ROR 0x01 k=1 -> 0x80, o_zero=0.
